// File: rtl/cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_miss_ctrl
// Brief    : Miss-handling / refill controller for a 4-way set-associative
//            cache. Victim = lowest invalid way, otherwise tree-PLRU.
//            Optional hit/miss counters enabled by macro CACHE_MISS_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cache_miss_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int TAG_WIDTH   = 4,
    parameter int INDEX_WIDTH = 4,
    parameter int WAY_NUM     = 4,
    parameter int LINE_WORDS  = 4,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     req_valid,
    input  logic [ADDR_WIDTH-1:0]                    req_addr,
    output logic                                     req_ready,
    input  logic [WAY_NUM-1:0]                       hit_en,
    output logic                                     resp_valid,
    output logic                                     resp_hit,
    output logic [WAY_NUM-1:0]                       resp_way,
    output logic                                     mem_req_valid,
    output logic [ADDR_WIDTH+$clog2(LINE_WORDS)-1:0] mem_req_addr,
    input  logic                                     mem_req_ready,
    input  logic                                     mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0]                    mem_rdata,
    output logic                                     refill_we,
    output logic [$clog2(LINE_WORDS)-1:0]            refill_word,
    output logic [DATA_WIDTH-1:0]                    refill_wdata,
    output logic                                     read_main_memory_en,
    output logic [ADDR_WIDTH-1:0]                    addr_to_main_memory,
    output logic [$clog2(WAY_NUM)+1:0]               replaced_way,
    output logic [15:0]                              perf_hit_cnt,
    output logic [15:0]                              perf_miss_cnt
);

    localparam int c_line_num = 2**INDEX_WIDTH;
    localparam int c_word_w   = $clog2(LINE_WORDS);
    localparam int c_way_w    = $clog2(WAY_NUM);
    localparam int c_code_w   = c_way_w + 2;
    localparam logic [c_word_w-1:0] c_last_word = c_word_w'(LINE_WORDS - 1);

    function automatic logic [c_way_w-1:0] lowest_way(input logic [WAY_NUM-1:0] v);
        lowest_way = '0;
        for (int i = WAY_NUM - 1; i >= 0; i--) begin
            if (v[i]) lowest_way = c_way_w'(i);
        end
    endfunction

    function automatic logic [WAY_NUM-1:0] way_onehot(input logic [c_way_w-1:0] w);
        way_onehot    = '0;
        way_onehot[w] = 1'b1;
    endfunction

    // Tree bits are {b2, b1, b0}: b0 picks the pair, b1/b2 pick within it.
    function automatic logic [c_way_w-1:0] plru_victim(input logic [2:0] t);
        if (t[0]) plru_victim = t[2] ? c_way_w'(3) : c_way_w'(2);
        else      plru_victim = t[1] ? c_way_w'(1) : c_way_w'(0);
    endfunction

    function automatic logic [2:0] plru_touch(input logic [2:0] t,
                                              input logic [c_way_w-1:0] w);
        plru_touch = t;
        case (w)
            c_way_w'(0): begin plru_touch[0] = 1'b1; plru_touch[1] = 1'b1; end
            c_way_w'(1): begin plru_touch[0] = 1'b1; plru_touch[1] = 1'b0; end
            c_way_w'(2): begin plru_touch[0] = 1'b0; plru_touch[2] = 1'b1; end
            default:     begin plru_touch[0] = 1'b0; plru_touch[2] = 1'b0; end
        endcase
    endfunction

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MREQ   = 3'd1,
        S_FILL   = 3'd2,
        S_COMMIT = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t                             state_q, state_d;
    logic [ADDR_WIDTH-1:0]              addr_q, addr_d;
    logic [c_way_w-1:0]                 victim_q, victim_d;
    logic [c_word_w-1:0]                cnt_q, cnt_d;
    logic                               hit_pulse_q, hit_pulse_d;
    logic [WAY_NUM-1:0]                 hit_way_q, hit_way_d;
    logic [c_line_num-1:0][WAY_NUM-1:0] valid_q, valid_d;
    logic [c_line_num-1:0][2:0]         plru_q, plru_d;

    logic [INDEX_WIDTH-1:0] w_req_idx;
    logic [INDEX_WIDTH-1:0] w_lat_idx;
    logic [WAY_NUM-1:0]     w_invalid;
    logic [c_way_w-1:0]     w_victim;
    logic [c_way_w-1:0]     w_hit_way;
    logic                   w_accept;
    logic                   w_hit;

    assign w_req_idx = req_addr[TAG_WIDTH +: INDEX_WIDTH];
    assign w_lat_idx = addr_q[TAG_WIDTH +: INDEX_WIDTH];
    assign w_invalid = ~valid_q[w_req_idx];
    assign w_hit_way = lowest_way(hit_en);
    assign w_victim  = (|w_invalid) ? lowest_way(w_invalid) : plru_victim(plru_q[w_req_idx]);
    assign w_accept  = (state_q == S_IDLE) && req_valid;
    assign w_hit     = |hit_en;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        victim_d    = victim_q;
        cnt_d       = cnt_q;
        hit_pulse_d = 1'b0;
        hit_way_d   = hit_way_q;
        valid_d     = valid_q;
        plru_d      = plru_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_hit) begin
                        hit_pulse_d       = 1'b1;
                        hit_way_d         = way_onehot(w_hit_way);
                        plru_d[w_req_idx] = plru_touch(plru_q[w_req_idx], w_hit_way);
                    end else begin
                        addr_d   = req_addr;
                        victim_d = w_victim;
                        state_d  = S_MREQ;
                    end
                end
            end
            S_MREQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_rdata_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == c_last_word) state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                valid_d[w_lat_idx][victim_q] = 1'b1;
                plru_d[w_lat_idx]            = plru_touch(plru_q[w_lat_idx], victim_q);
                state_d                      = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            victim_q    <= '0;
            cnt_q       <= '0;
            hit_pulse_q <= 1'b0;
            hit_way_q   <= '0;
            valid_q     <= '0;
            plru_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            victim_q    <= victim_d;
            cnt_q       <= cnt_d;
            hit_pulse_q <= hit_pulse_d;
            hit_way_q   <= hit_way_d;
            valid_q     <= valid_d;
            plru_q      <= plru_d;
        end
    end

    assign req_ready           = (state_q == S_IDLE);
    assign resp_valid          = hit_pulse_q || (state_q == S_RESP);
    assign resp_hit            = hit_pulse_q;
    assign resp_way            = hit_pulse_q ? hit_way_q :
                                 ((state_q == S_RESP) ? way_onehot(victim_q) : '0);
    assign mem_req_valid       = (state_q == S_MREQ);
    assign mem_req_addr        = (state_q == S_MREQ) ? {addr_q, {c_word_w{1'b0}}} : '0;
    assign refill_we           = (state_q == S_FILL) && mem_rdata_valid;
    assign refill_word         = cnt_q;
    assign refill_wdata        = mem_rdata;
    assign read_main_memory_en = (state_q == S_COMMIT);
    assign addr_to_main_memory = (state_q == S_COMMIT) ? addr_q : '0;
    assign replaced_way        = (state_q == S_COMMIT) ? c_code_w'(way_onehot(victim_q)) : '0;

`ifdef CACHE_MISS_PERF_EN
    logic [15:0] perf_hit_q, perf_hit_d;
    logic [15:0] perf_miss_q, perf_miss_d;

    // Counters saturate rather than wrap.
    always_comb begin
        perf_hit_d  = perf_hit_q;
        perf_miss_d = perf_miss_q;
        if (w_accept && w_hit && (perf_hit_q != 16'hFFFF))
            perf_hit_d = perf_hit_q + 16'd1;
        if (w_accept && !w_hit && (perf_miss_q != 16'hFFFF))
            perf_miss_d = perf_miss_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else begin
            perf_hit_q  <= perf_hit_d;
            perf_miss_q <= perf_miss_d;
        end
    end

    assign perf_hit_cnt  = perf_hit_q;
    assign perf_miss_cnt = perf_miss_q;
`else
    assign perf_hit_cnt  = 16'd0;
    assign perf_miss_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_miss_ctrl
// Brief    : Directed, table-driven bench for cache_miss_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_miss_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [3:0]  hit_en = '0;
    logic        mem_req_ready = 1'b0;
    logic        mem_rdata_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        req_ready, resp_valid, resp_hit, mem_req_valid, refill_we, read_main_memory_en;
    logic [3:0]  resp_way, replaced_way;
    logic [9:0]  mem_req_addr;
    logic [1:0]  refill_word;
    logic [31:0] refill_wdata;
    logic [7:0]  addr_to_main_memory;
    logic [15:0] perf_hit_cnt, perf_miss_cnt;

    always #5 clk = ~clk;

    cache_miss_ctrl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_valid           (req_valid),
        .req_addr            (req_addr),
        .req_ready           (req_ready),
        .hit_en              (hit_en),
        .resp_valid          (resp_valid),
        .resp_hit            (resp_hit),
        .resp_way            (resp_way),
        .mem_req_valid       (mem_req_valid),
        .mem_req_addr        (mem_req_addr),
        .mem_req_ready       (mem_req_ready),
        .mem_rdata_valid     (mem_rdata_valid),
        .mem_rdata           (mem_rdata),
        .refill_we           (refill_we),
        .refill_word         (refill_word),
        .refill_wdata        (refill_wdata),
        .read_main_memory_en (read_main_memory_en),
        .addr_to_main_memory (addr_to_main_memory),
        .replaced_way        (replaced_way),
        .perf_hit_cnt        (perf_hit_cnt),
        .perf_miss_cnt       (perf_miss_cnt)
    );

    typedef struct packed {
        logic        req_ready;
        logic        resp_valid;
        logic        resp_hit;
        logic [3:0]  resp_way;
        logic        mem_req_valid;
        logic [9:0]  mem_req_addr;
        logic        refill_we;
        logic [1:0]  refill_word;
        logic [31:0] refill_wdata;
        logic        rd_en;
        logic [7:0]  a2m;
        logic [3:0]  rway;
    } exp_t;

    typedef struct {
        string       name;
        logic        rn;
        logic        rv;
        logic [7:0]  addr;
        logic [3:0]  hit;
        logic        mready;
        logic        mvalid;
        logic [31:0] mdata;
        exp_t        e;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    function automatic exp_t e_idle();
        exp_t e = '0;
        e.req_ready = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_hit(logic [3:0] w);
        exp_t e = e_idle();
        e.resp_valid = 1'b1;
        e.resp_hit   = 1'b1;
        e.resp_way   = w;
        return e;
    endfunction

    function automatic exp_t e_mreq(logic [7:0] a);
        exp_t e = '0;
        e.mem_req_valid = 1'b1;
        e.mem_req_addr  = {a, 2'b00};
        return e;
    endfunction

    function automatic exp_t e_fill(logic [1:0] word, logic we);
        exp_t e = '0;
        e.refill_word = word;
        e.refill_we   = we;
        return e;
    endfunction

    function automatic exp_t e_commit(logic [7:0] a, logic [3:0] w);
        exp_t e = '0;
        e.rd_en = 1'b1;
        e.a2m   = a;
        e.rway  = w;
        return e;
    endfunction

    function automatic exp_t e_resp(logic [3:0] w);
        exp_t e = '0;
        e.resp_valid = 1'b1;
        e.resp_way   = w;
        return e;
    endfunction

    // refill_wdata mirrors mem_rdata combinationally, so it follows the stimulus.
    function automatic vec_t mk(string n, logic rn, logic rv, logic [7:0] a, logic [3:0] h,
                                logic mr, logic mv, logic [31:0] d, exp_t e);
        vec_t v;
        v.name = n; v.rn = rn; v.rv = rv; v.addr = a; v.hit = h;
        v.mready = mr; v.mvalid = mv; v.mdata = d;
        v.e = e;
        v.e.refill_wdata = d;
        return v;
    endfunction

    task automatic gen_miss(string n, logic [7:0] a, logic [3:0] w);
        logic [31:0] d;
        tbl.push_back(mk({n, "_req"}, 1'b1, 1'b1, a, 4'b0000, 1'b0, 1'b0, 32'h0, e_idle()));
        tbl.push_back(mk({n, "_mreq"}, 1'b1, 1'b0, a, 4'b0000, 1'b1, 1'b0, 32'h0, e_mreq(a)));
        for (int i = 0; i < 4; i++) begin
            d = {a, 24'h00BEE0} + 32'(i);
            tbl.push_back(mk({n, "_beat"}, 1'b1, 1'b0, a, 4'b0000, 1'b0, 1'b1, d,
                             e_fill(2'(i), 1'b1)));
        end
        tbl.push_back(mk({n, "_commit"}, 1'b1, 1'b0, a, 4'b0000, 1'b0, 1'b0, 32'h0, e_commit(a, w)));
        tbl.push_back(mk({n, "_resp"}, 1'b1, 1'b0, a, 4'b0000, 1'b0, 1'b0, 32'h0, e_resp(w)));
    endtask

    task automatic gen_hit(string n, logic [7:0] a, logic [3:0] h, logic [3:0] w);
        tbl.push_back(mk({n, "_req"}, 1'b1, 1'b1, a, h, 1'b0, 1'b0, 32'h0, e_idle()));
        tbl.push_back(mk({n, "_resp"}, 1'b1, 1'b0, a, 4'b0000, 1'b0, 1'b0, 32'h0, e_hit(w)));
    endtask

    task automatic apply(input vec_t v);
        exp_t act;
        rst_n           = v.rn;
        req_valid       = v.rv;
        req_addr        = v.addr;
        hit_en          = v.hit;
        mem_req_ready   = v.mready;
        mem_rdata_valid = v.mvalid;
        mem_rdata       = v.mdata;
        @(negedge clk);
        act = {req_ready, resp_valid, resp_hit, resp_way, mem_req_valid, mem_req_addr,
               refill_we, refill_word, refill_wdata, read_main_memory_en,
               addr_to_main_memory, replaced_way};
        n_vec++;
        if (act !== v.e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", v.name, act, v.e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        tbl.delete();
    endtask

    task automatic check16(string n, logic [15:0] act, logic [15:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp_v);
        end
    endtask

    initial begin
        // ---------------- table: fill set 3, hits, PLRU victims ----------------
        tbl.push_back(mk("reset_state", 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 32'h0, e_idle()));
        gen_miss("miss35", 8'h35, 4'b0001);
        gen_miss("miss36", 8'h36, 4'b0010);
        gen_miss("miss37", 8'h37, 4'b0100);
        gen_miss("miss38", 8'h38, 4'b1000);
        gen_hit("hit35_w2", 8'h35, 4'b0100, 4'b0100);
        gen_miss("miss39_plru", 8'h39, 4'b0001);
        gen_hit("hit38_multi", 8'h38, 4'b1100, 4'b0100);
        gen_miss("miss3a_plru", 8'h3A, 4'b0010);
        gen_miss("miss3b_plru", 8'h3B, 4'b1000);
        gen_hit("hit50_w0", 8'h50, 4'b0001, 4'b0001);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_tbl();

        // ---------------- memory request stall, stray beat, beat gaps ----------------
        apply(mk("stall_req", 1'b1, 1'b1, 8'h72, 4'b0000, 1'b0, 1'b0, 32'h0, e_idle()));
        for (int i = 0; i < 5; i++)
            apply(mk("stall_wait", 1'b1, 1'b1, 8'h99, 4'b0000, 1'b0, (i == 2),
                     (i == 2) ? 32'hDEAD0000 : 32'h0, e_mreq(8'h72)));
        apply(mk("stall_go", 1'b1, 1'b0, 8'h99, 4'b0000, 1'b1, 1'b0, 32'h0, e_mreq(8'h72)));
        apply(mk("gap_b0", 1'b1, 1'b0, 8'h99, 4'b0000, 1'b0, 1'b1, 32'h11, e_fill(2'd0, 1'b1)));
        apply(mk("gap_idle1", 1'b1, 1'b0, 8'h99, 4'b0000, 1'b0, 1'b0, 32'h0, e_fill(2'd1, 1'b0)));
        apply(mk("gap_b1", 1'b1, 1'b0, 8'h99, 4'b0000, 1'b0, 1'b1, 32'h22, e_fill(2'd1, 1'b1)));
        apply(mk("gap_b2", 1'b1, 1'b0, 8'h99, 4'b0000, 1'b0, 1'b1, 32'h33, e_fill(2'd2, 1'b1)));
        apply(mk("gap_idle3", 1'b1, 1'b0, 8'h99, 4'b0000, 1'b0, 1'b0, 32'h0, e_fill(2'd3, 1'b0)));
        apply(mk("gap_b3", 1'b1, 1'b0, 8'h99, 4'b0000, 1'b0, 1'b1, 32'h44, e_fill(2'd3, 1'b1)));
        apply(mk("stall_commit", 1'b1, 1'b0, 8'h99, 4'b0000, 1'b0, 1'b0, 32'h0, e_commit(8'h72, 4'b0001)));
        apply(mk("stall_resp", 1'b1, 1'b0, 8'h99, 4'b0000, 1'b0, 1'b0, 32'h0, e_resp(4'b0001)));
        apply(mk("stall_after", 1'b1, 1'b0, 8'h99, 4'b0000, 1'b0, 1'b0, 32'h0, e_idle()));

        // ---------------- reset in the middle of a refill ----------------
        gen_hit("hit35_w0", 8'h35, 4'b0001, 4'b0001);
        run_tbl();
        apply(mk("rf_req", 1'b1, 1'b1, 8'h3C, 4'b0000, 1'b0, 1'b0, 32'h0, e_idle()));
        apply(mk("rf_mreq", 1'b1, 1'b0, 8'h3C, 4'b0000, 1'b1, 1'b0, 32'h0, e_mreq(8'h3C)));
        for (int i = 0; i < 3; i++)
            apply(mk("rf_beat", 1'b1, 1'b0, 8'h3C, 4'b0000, 1'b0, 1'b1, 32'h700 + 32'(i),
                     e_fill(2'(i), 1'b1)));
        apply(mk("rf_reset", 1'b0, 1'b0, 8'h3C, 4'b0000, 1'b0, 1'b0, 32'h0, e_fill(2'd3, 1'b0)));
        apply(mk("rf_late_beat", 1'b1, 1'b0, 8'h3C, 4'b0000, 1'b0, 1'b1, 32'h703, e_idle()));
        apply(mk("rf_late_beat2", 1'b1, 1'b0, 8'h3C, 4'b0000, 1'b0, 1'b1, 32'h704, e_idle()));
        gen_miss("post_rst35", 8'h35, 4'b0001);
        gen_miss("post_rst36", 8'h36, 4'b0010);
        run_tbl();

        // ---------------- performance counters ----------------
        apply(mk("perf_rst", 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 32'h0, e_idle()));
        apply(mk("perf_idle", 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 32'h0, e_idle()));
        check16("perf_hit_reset", perf_hit_cnt, 16'd0);
        check16("perf_miss_reset", perf_miss_cnt, 16'd0);
        gen_hit("perf_h1", 8'h10, 4'b0001, 4'b0001);
        gen_hit("perf_h2", 8'h20, 4'b0010, 4'b0010);
        gen_hit("perf_h3", 8'h30, 4'b1000, 4'b1000);
        gen_miss("perf_m1", 8'hA1, 4'b0001);
        gen_miss("perf_m2", 8'hA2, 4'b0010);
        run_tbl();
`ifdef CACHE_MISS_PERF_EN
        check16("perf_hit_cnt", perf_hit_cnt, 16'd3);
        check16("perf_miss_cnt", perf_miss_cnt, 16'd2);
`else
        check16("perf_hit_cnt", perf_hit_cnt, 16'd0);
        check16("perf_miss_cnt", perf_miss_cnt, 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
